// File: rtl/ram_access_sequencer_pkg.sv
// Shared definitions for the RAM access sequencer: access codes,
// sequencer state encoding and small code-classification helpers.
package ram_access_sequencer_pkg;

  typedef enum logic [3:0] {
    ACC_NONE           = 4'd0,
    ACC_RD_RAM_REG     = 4'd1,
    ACC_WR_RAM_REG     = 4'd2,
    ACC_RD_RAM_REG_IND = 4'd3,
    ACC_WR_RAM_REG_IND = 4'd4,
    ACC_RD_RAM_DIRECT  = 4'd5,
    ACC_RD_RAM_IM      = 4'd6,
    ACC_WR_RAM_DIRECT  = 4'd7
  } access_code_e;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PTR_RD   = 3'd1,
    S_PTR_WAIT = 3'd2,
    S_ACCESS   = 3'd3,
    S_RD_WAIT  = 3'd4,
    S_DONE     = 3'd5
  } seq_state_e;

  // Codes 8-15 are not defined.
  function automatic logic is_illegal(input logic [3:0] code);
    return code[3];
  endfunction

  function automatic logic is_indirect(input logic [3:0] code);
    return (code == ACC_RD_RAM_REG_IND) || (code == ACC_WR_RAM_REG_IND);
  endfunction

  // Codes that go through the ACCESS state and perform a RAM read there.
  function automatic logic is_ram_read(input logic [3:0] code);
    return (code == ACC_RD_RAM_REG) || (code == ACC_RD_RAM_REG_IND) ||
           (code == ACC_RD_RAM_DIRECT);
  endfunction

  // Codes that complete without touching RAM.
  function automatic logic is_no_ram(input logic [3:0] code);
    return is_illegal(code) || (code == ACC_NONE) || (code == ACC_RD_RAM_IM);
  endfunction

endpackage

// File: rtl/ram_addr_gen.sv
// Combinational RAM address mux: Ri pointer address during the pointer
// fetch, otherwise register, indirect (latched pointer) or direct address.
module ram_addr_gen
  import ram_access_sequencer_pkg::*;
(
  input  logic [3:0] code,
  input  logic       ptr_phase,
  input  logic [7:0] operand,
  input  logic [2:0] reg_sel,
  input  logic [1:0] bank_sel,
  input  logic [7:0] ptr,
  output logic [7:0] addr
);

  // Select the address source for the current access.
  always_comb begin
    addr = 8'h00;
    if (ptr_phase) begin
      addr = {3'b000, bank_sel, 2'b00, reg_sel[0]};
    end else begin
      case (code)
        ACC_RD_RAM_REG, ACC_WR_RAM_REG:         addr = {3'b000, bank_sel, reg_sel};
        ACC_RD_RAM_REG_IND, ACC_WR_RAM_REG_IND: addr = ptr;
        ACC_RD_RAM_DIRECT, ACC_WR_RAM_DIRECT:   addr = operand;
        default:                                addr = 8'h00;
      endcase
    end
  end

endmodule

// File: rtl/ram_access_sequencer.sv
// Sequences register, indirect, direct and immediate accesses to the
// internal RAM (synchronous-read) and delivers the operand to the datapath.
module ram_access_sequencer
  import ram_access_sequencer_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] access_code,
  input  logic [7:0] operand,
  input  logic [2:0] reg_sel,
  input  logic [1:0] bank_sel,
  input  logic [7:0] acc_in,
  input  logic [7:0] ram_rdata,
  output logic [7:0] ram_addr,
  output logic       ram_rd_en,
  output logic       ram_wr_en,
  output logic [7:0] ram_wdata,
  output logic [7:0] data_out,
  output logic       busy,
  output logic       done,
  output logic       err
);

  seq_state_e state, state_nxt;

  logic [3:0] code_q;
  logic [7:0] operand_q;
  logic [2:0] reg_q;
  logic [1:0] bank_q;
  logic [7:0] acc_q;
  logic [7:0] ptr_q;
  logic [7:0] dout_q;
  logic [7:0] addr_mux;
  logic       accept;

  assign accept = (state == S_IDLE) && start;

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Capture the request once in IDLE; later input changes are ignored.
  always_ff @(posedge clock) begin
    if (!reset) begin
      code_q    <= ACC_NONE;
      operand_q <= 8'h00;
      reg_q     <= 3'd0;
      bank_q    <= 2'd0;
      acc_q     <= 8'h00;
    end else if (accept) begin
      code_q    <= access_code;
      operand_q <= operand;
      reg_q     <= reg_sel;
      bank_q    <= bank_sel;
      acc_q     <= acc_in;
    end
  end

  // Indirect pointer arrives one cycle after the PTR_RD strobe.
  always_ff @(posedge clock) begin
    if (!reset)                   ptr_q <= 8'h00;
    else if (state == S_PTR_WAIT) ptr_q <= ram_rdata;
  end

  // data_out changes only on a read or immediate completion.
  always_ff @(posedge clock) begin
    if (!reset)                                      dout_q <= 8'h00;
    else if (accept && (access_code == ACC_RD_RAM_IM)) dout_q <= operand;
    else if (state == S_RD_WAIT)                     dout_q <= ram_rdata;
  end

  // Next-state and strobe decode.
  always_comb begin
    state_nxt = state;
    ram_rd_en = 1'b0;
    ram_wr_en = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (is_no_ram(access_code))        state_nxt = S_DONE;
          else if (is_indirect(access_code)) state_nxt = S_PTR_RD;
          else                               state_nxt = S_ACCESS;
        end
      end
      S_PTR_RD: begin
        ram_rd_en = 1'b1;
        state_nxt = S_PTR_WAIT;
      end
      S_PTR_WAIT: state_nxt = S_ACCESS;
      S_ACCESS: begin
        if (is_ram_read(code_q)) begin
          ram_rd_en = 1'b1;
          state_nxt = S_RD_WAIT;
        end else begin
          ram_wr_en = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_RD_WAIT: state_nxt = S_DONE;
      S_DONE: begin
        done      = 1'b1;
        err       = is_illegal(code_q);
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  ram_addr_gen u_addr_gen (
    .code      (code_q),
    .ptr_phase (state == S_PTR_RD),
    .operand   (operand_q),
    .reg_sel   (reg_q),
    .bank_sel  (bank_q),
    .ptr       (ptr_q),
    .addr      (addr_mux)
  );

  assign ram_addr  = (ram_rd_en || ram_wr_en) ? addr_mux : 8'h00;
  assign ram_wdata = acc_q;
  assign data_out  = dout_q;
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_ram_access_sequencer.sv
// Scoreboard bench for ram_access_sequencer with a behavioural RAM.
module tb_ram_access_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] access_code;
  logic [7:0] operand;
  logic [2:0] reg_sel;
  logic [1:0] bank_sel;
  logic [7:0] acc_in;
  logic [7:0] ram_rdata;
  logic [7:0] ram_addr;
  logic       ram_rd_en;
  logic       ram_wr_en;
  logic [7:0] ram_wdata;
  logic [7:0] data_out;
  logic       busy;
  logic       done;
  logic       err;

  ram_access_sequencer dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .access_code (access_code),
    .operand     (operand),
    .reg_sel     (reg_sel),
    .bank_sel    (bank_sel),
    .acc_in      (acc_in),
    .ram_rdata   (ram_rdata),
    .ram_addr    (ram_addr),
    .ram_rd_en   (ram_rd_en),
    .ram_wr_en   (ram_wr_en),
    .ram_wdata   (ram_wdata),
    .data_out    (data_out),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clock = ~clock;

  typedef struct {
    int cyc;
    int dout;
    int err;
  } exp_t;

  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];
  exp_t exp_q[$];
  int   rd_q[$];
  int   wr_q[$];
  int   checks    = 0;
  int   errors    = 0;
  int   cyc       = 0;
  int   done_cnt  = 0;
  int   exp_done  = 0;
  int   ref_dout  = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Synchronous-read RAM.
  always @(posedge clock) begin
    if (ram_wr_en) mem[ram_addr] <= ram_wdata;
    if (ram_rd_en) ram_rdata <= mem[ram_addr];
  end

  // Monitor: compare every strobe and every completion against the queues.
  always @(negedge clock) begin
    exp_t e;
    int   a;
    if (ram_rd_en === 1'b1) begin
      if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
      else begin
        a = rd_q.pop_front();
        chk("rd_addr", int'(ram_addr), a);
      end
    end
    if (ram_wr_en === 1'b1) begin
      if (wr_q.size() == 0) chk("wr_unexpected", 1, 0);
      else begin
        a = wr_q.pop_front();
        chk("wr_addr_data", int'({ram_addr, ram_wdata}), a);
      end
    end
    if (done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) chk("done_unexpected", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("data_out", int'(data_out), e.dout);
        chk("err", int'(err), e.err);
      end
    end else if (err === 1'b1) begin
      chk("err_without_done", 1, 0);
    end
  end

  // Drive a request and push the reference model's expectations.
  task automatic start_op(input int code, input int opnd, input int rs,
                          input int bs, input int acc);
    int   ra, pa, p, lat;
    exp_t e;
    @(negedge clock);
    access_code = 4'(code);
    operand     = 8'(opnd);
    reg_sel     = 3'(rs);
    bank_sel    = 2'(bs);
    acc_in      = 8'(acc);
    start       = 1'b1;
    ra    = bs * 8 + rs;
    pa    = bs * 8 + (rs % 2);
    e.err = 0;
    lat   = 1;
    case (code)
      0: lat = 1;
      1: begin rd_q.push_back(ra); ref_dout = ref_mem[ra]; lat = 3; end
      2: begin wr_q.push_back(ra * 256 + acc); ref_mem[ra] = 8'(acc); lat = 2; end
      3: begin
        rd_q.push_back(pa); p = ref_mem[pa];
        rd_q.push_back(p);  ref_dout = ref_mem[p]; lat = 5;
      end
      4: begin
        rd_q.push_back(pa); p = ref_mem[pa];
        wr_q.push_back(p * 256 + acc); ref_mem[p] = 8'(acc); lat = 4;
      end
      5: begin rd_q.push_back(opnd); ref_dout = ref_mem[opnd]; lat = 3; end
      6: ref_dout = opnd;
      7: begin wr_q.push_back(opnd * 256 + acc); ref_mem[opnd] = 8'(acc); lat = 2; end
      default: e.err = 1;
    endcase
    e.dout = ref_dout;
    @(posedge clock);
    #1;
    e.cyc = cyc + lat - 1;
    exp_q.push_back(e);
    exp_done++;
  endtask

  // Scramble inputs (and possibly start) while busy, then release start in IDLE.
  task automatic finish_op(input bit force_start);
    bit idle = 1'b0;
    for (int k = 0; k < 16 && !idle; k++) begin
      @(negedge clock);
      if (busy) begin
        start       = force_start ? 1'b1 : 1'($urandom_range(0, 1));
        access_code = 4'($urandom_range(0, 15));
        operand     = 8'($urandom_range(0, 255));
        reg_sel     = 3'($urandom_range(0, 7));
        bank_sel    = 2'($urandom_range(0, 3));
        acc_in      = 8'($urandom_range(0, 255));
      end else begin
        start = 1'b0;
        idle  = 1'b1;
      end
    end
    if (!idle) begin
      chk("busy_timeout", 1, 0);
      start = 1'b0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ram_addr"},  int'(ram_addr), 0);
    chk({tag, "_rd_en"},     int'(ram_rd_en), 0);
    chk({tag, "_wr_en"},     int'(ram_wr_en), 0);
    chk({tag, "_wdata"},     int'(ram_wdata), 0);
    chk({tag, "_data_out"},  int'(data_out), 0);
    chk({tag, "_busy"},      int'(busy), 0);
    chk({tag, "_done"},      int'(done), 0);
    chk({tag, "_err"},       int'(err), 0);
  endtask

  initial begin
    int d0;
    reset = 1'b0; start = 1'b0; access_code = '0; operand = '0;
    reg_sel = '0; bank_sel = '0; acc_in = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 8'($urandom_range(0, 255));
      ref_mem[i] = mem[i];
    end
    mem[8'h15] = 8'h3C; ref_mem[8'h15] = 8'h3C;
    mem[8'h09] = 8'h40; ref_mem[8'h09] = 8'h40;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_all_zero("reset");
    reset = 1'b1;

    // Register read, bank 2 reg 5.
    start_op(1, 8'h00, 5, 2, 8'h11);
    finish_op(1'b0);
    chk("rd_reg_dout", int'(data_out), 8'h3C);

    // Indirect write through R1 of bank 1.
    start_op(4, 8'h00, 1, 1, 8'hA5);
    finish_op(1'b0);
    chk("wr_ind_mem", int'(mem[8'h40]), 8'hA5);

    // Immediate.
    start_op(6, 8'h7E, 0, 0, 0);
    finish_op(1'b0);
    chk("im_dout", int'(data_out), 8'h7E);

    // Illegal code leaves data_out alone.
    start_op(9, 8'h55, 3, 3, 8'h66);
    finish_op(1'b0);
    chk("illegal_dout", int'(data_out), 8'h7E);

    // Direct read with start held high throughout busy.
    d0 = done_cnt;
    start_op(5, 8'h30, 0, 0, 0);
    finish_op(1'b1);
    repeat (2) @(negedge clock);
    chk("single_done", done_cnt - d0, 1);

    // Reset while waiting for the pointer.
    start_op(3, 8'h00, 0, 3, 0);
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    chk("ptr_wait_busy", int'(busy), 1);
    reset = 1'b0;
    exp_q.delete(); rd_q.delete(); wr_q.delete();
    exp_done--;
    ref_dout = 0;
    d0 = done_cnt;
    @(negedge clock);
    check_all_zero("abort");
    reset = 1'b1;
    repeat (4) @(negedge clock);
    chk("abort_no_done", done_cnt - d0, 0);

    // Randomised traffic.
    for (int n = 0; n < 200; n++) begin
      start_op($urandom_range(0, 15), $urandom_range(0, 255), $urandom_range(0, 7),
               $urandom_range(0, 3), $urandom_range(0, 255));
      finish_op($urandom_range(0, 7) == 0);
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    repeat (4) @(negedge clock);
    chk("queues_empty", exp_q.size() + rd_q.size() + wr_q.size(), 0);
    chk("done_total", done_cnt, exp_done);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL global_timeout: actual=%0d required=0", 1);
    $fatal(1, "timeout");
  end

endmodule
